// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } reset_seq_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Shift-register synchroniser for a single-bit asynchronous level; clears to 0 on rst.
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises and stretches a board reset request, then releases the channel resets in order.
// Optional soft-reset input sw_rst_req is present when RESET_SEQ_SW_REQ_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_n_req_async,
`ifdef RESET_SEQ_SW_REQ_EN
    input  logic                    sw_rst_req,
`endif
    output logic [NUM_CHANNELS-1:0] rst_n_out,
    output logic                    seq_busy,
    output logic                    seq_done,
    output reset_seq_state_t        dbg_state
);

    localparam int CW = cnt_width((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
    localparam int IW = $clog2(NUM_CHANNELS) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CHANNELS - 1);
    // A single channel has nothing to stagger, so the hold phase ends the sequence.
    localparam reset_seq_state_t AFTER_HOLD = (NUM_CHANNELS == 1) ? ST_DONE : ST_RELEASE;

    reset_seq_state_t        state, state_next;
    logic [CW-1:0]           hold_cnt, hold_next;
    logic [CW-1:0]           gap_cnt, gap_next;
    logic [IW-1:0]           idx, idx_next, idx_inc;
    logic [NUM_CHANNELS-1:0] rst_n_next;
    logic                    busy_next;
    logic                    done_next;
    logic                    req_sync;
    logic                    assert_req;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rst_n_req_async),
        .q   (req_sync)
    );

`ifdef RESET_SEQ_SW_REQ_EN
    assign assert_req = !req_sync || sw_rst_req;
`else
    assign assert_req = !req_sync;
`endif

    assign idx_inc = idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ASSERT;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            idx       <= '0;
            rst_n_out <= '0;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            gap_cnt   <= gap_next;
            idx       <= idx_next;
            rst_n_out <= rst_n_next;
            seq_busy  <= busy_next;
            seq_done  <= done_next;
        end
    end

    // Re-assert wins over every other transition and clears all progress.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        gap_next   = gap_cnt;
        idx_next   = idx;
        if (assert_req) begin
            state_next = ST_ASSERT;
            hold_next  = '0;
            gap_next   = '0;
            idx_next   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    state_next = ST_HOLD;
                    hold_next  = '0;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = AFTER_HOLD;
                        gap_next   = '0;
                        idx_next   = '0;
                    end else begin
                        hold_next = hold_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_next = '0;
                        idx_next = idx_inc;
                        if (idx_inc == IDX_LAST) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        gap_next = gap_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_ASSERT;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so every released bit stays high.
    always_comb begin
        rst_n_next = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            rst_n_next[k] = (state_next == ST_DONE) ||
                            ((state_next == ST_RELEASE) && (IW'(k) <= idx_next));
        end
        busy_next = (state_next != ST_DONE);
        done_next = (state_next == ST_DONE);
    end

    assign dbg_state = state;

endmodule
